// File: rtl/mlp_result_sink.sv
// Frame-level result sink for the MLP accelerator: takes a label, then NUM_CLASSES signed
// scores, reports the argmax and whether it matched, and keeps saturating accuracy totals.
module mlp_result_sink #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int NUM_CLASSES            = 10,
   parameter int LABEL_WIDTH            = 4,
   parameter int CNT_WIDTH              = 16
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   output logic                                  s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,
   input  logic                                  s00_axis_tvalid,
   input  logic [LABEL_WIDTH-1:0]                label_data,
   input  logic                                  label_valid,
   output logic                                  label_ready,
   input  logic                                  clear,
   output logic [LABEL_WIDTH-1:0]                class_out,
   output logic                                  class_valid,
   output logic                                  correct,
   output logic                                  frame_err,
   output logic [CNT_WIDTH-1:0]                  total_cnt,
   output logic [CNT_WIDTH-1:0]                  correct_cnt
);

   typedef enum logic [1:0] {WAIT_LABEL, RECV, DRAIN, RESULT} state_t;

   localparam logic [LABEL_WIDTH-1:0] LAST_IDX = LABEL_WIDTH'(NUM_CLASSES - 1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic en);
      if (en && (v != '1)) sat_inc = v + CNT_WIDTH'(1);
      else                 sat_inc = v;
   endfunction

   state_t                              state_q, state_d;
   logic [LABEL_WIDTH-1:0]              idx_q, idx_d;
   logic [LABEL_WIDTH-1:0]              maxidx_q, maxidx_d;
   logic [LABEL_WIDTH-1:0]              label_q, label_d;
   logic [LABEL_WIDTH-1:0]              cls_hold_q, cls_hold_d;
   logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] max_q, max_d;
   logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] beat_s;
   logic                                err_q, err_d;
   logic [CNT_WIDTH-1:0]                total_q, total_d;
   logic [CNT_WIDTH-1:0]                corr_q, corr_d;
   logic                                beat_hs, label_hs, hit;

   // Byte strobes carry no meaning for score words.
   wire unused_tstrb = &{1'b0, s00_axis_tstrb};

   assign beat_s   = s00_axis_tdata;
   assign beat_hs  = s00_axis_tvalid && s00_axis_tready;
   assign label_hs = label_valid && label_ready;
   assign hit      = (maxidx_q == label_q);

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) state_q <= WAIT_LABEL;
      else                   state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_LABEL: if (label_hs) state_d = RECV;
         RECV: begin
            if (beat_hs) begin
               if (s00_axis_tlast)        state_d = RESULT;
               else if (idx_q == LAST_IDX) state_d = DRAIN;
            end
         end
         DRAIN:      if (beat_hs && s00_axis_tlast) state_d = RESULT;
         RESULT:     state_d = WAIT_LABEL;
         default:    state_d = WAIT_LABEL;
      endcase
   end

   always_comb begin
      s00_axis_tready = (state_q == RECV) || (state_q == DRAIN);
      label_ready     = (state_q == WAIT_LABEL);
      class_valid     = (state_q == RESULT);
      class_out       = (state_q == RESULT) ? maxidx_q : cls_hold_q;
      correct         = (state_q == RESULT) && hit;
      frame_err       = (state_q == RESULT) && err_q;
      total_cnt       = total_q;
      correct_cnt     = corr_q;
   end

   always_comb begin
      idx_d      = idx_q;
      maxidx_d   = maxidx_q;
      max_d      = max_q;
      label_d    = label_q;
      err_d      = err_q;
      cls_hold_d = cls_hold_q;
      case (state_q)
         WAIT_LABEL: begin
            if (label_hs) begin
               label_d = label_data;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         RECV: begin
            if (beat_hs) begin
               // Strict greater-than keeps the lowest index on ties.
               if ((idx_q == '0) || (beat_s > max_q)) begin
                  max_d    = beat_s;
                  maxidx_d = idx_q;
               end
               idx_d = idx_q + LABEL_WIDTH'(1);
               if (s00_axis_tlast ? (idx_q != LAST_IDX) : (idx_q == LAST_IDX)) err_d = 1'b1;
            end
         end
         RESULT:  cls_hold_d = maxidx_q;
         default: ;
      endcase
   end

   always_comb begin
      total_d = sat_inc(total_q, state_q == RESULT);
      corr_d  = sat_inc(corr_q, (state_q == RESULT) && hit);
      if (clear) begin
         total_d = '0;
         corr_d  = '0;
      end
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         idx_q      <= '0;
         maxidx_q   <= '0;
         max_q      <= '0;
         label_q    <= '0;
         err_q      <= 1'b0;
         cls_hold_q <= '0;
         total_q    <= '0;
         corr_q     <= '0;
      end else begin
         idx_q      <= idx_d;
         maxidx_q   <= maxidx_d;
         max_q      <= max_d;
         label_q    <= label_d;
         err_q      <= err_d;
         cls_hold_q <= cls_hold_d;
         total_q    <= total_d;
         corr_q     <= corr_d;
      end
   end

endmodule

// File: doc/mlp_result_sink.md
Name: mlp_result_sink

Overview:
- AXI-Stream receiver on the far end of the accelerator's m00_axis output port.
- Per frame it accepts one expected label, then NUM_CLASSES signed output scores. It computes the argmax, compares it with the label, and keeps saturating totals for frames and correct classifications.
- Provides an in-hardware accuracy counter for on-board MNIST runs, so the host only reads two counters.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, score word width; each beat carries one two's-complement score.
- NUM_CLASSES, 10, beats per frame; must be ≥ 2.
- LABEL_WIDTH, 4, label/class index width; requires 2^LABEL_WIDTH ≥ NUM_CLASSES.
- CNT_WIDTH, 16, width of the frame and correct counters.

Ports:
- s00_axis_aclk, in, 1, single clock; all logic on its rising edge.
- s00_axis_aresetn, in, 1, asynchronous active-low reset.
- s00_axis_tready, out, 1, sink ready.
- s00_axis_tdata, in, C_S00_AXIS_TDATA_WIDTH, score.
- s00_axis_tstrb, in, C_S00_AXIS_TDATA_WIDTH/8, ignored; all bytes are treated as valid.
- s00_axis_tlast, in, 1, last score of frame.
- s00_axis_tvalid, in, 1, score valid.
- label_data, in, LABEL_WIDTH, expected class for the next frame.
- label_valid, in, 1, label valid.
- label_ready, out, 1, label accepted when valid && ready.
- clear, in, 1, synchronous clear of the counters.
- class_out, out, LABEL_WIDTH, argmax of the last frame.
- class_valid, out, 1, one-cycle pulse with class_out.
- correct, out, 1, class_out == latched label; valid with class_valid.
- frame_err, out, 1, one-cycle pulse; tlast position was wrong in the last frame.
- total_cnt, out, CNT_WIDTH, frames completed.
- correct_cnt, out, CNT_WIDTH, frames classified correctly.

Behaviour:
- Reset (async assert, sync release):
  - State goes to WAIT_LABEL.
  - All outputs are 0 except label_ready, which is 1 after reset.
  - Beat index, max value, max index and latched label are all cleared.
- WAIT_LABEL:
  - label_ready=1, s00_axis_tready=0.
  - On label handshake: latch label_data, beat index:=0, go to RECV.
- RECV:
  - s00_axis_tready=1, label_ready=0.
  - Each accepted beat (tvalid && tready) is compared signed.
  - Beat 0 loads max unconditionally. Later beats replace max only if strictly greater, so ties keep the lower index.
  - Beat index increments per accepted beat.
- End of frame:
  - Normal end: tlast on beat NUM_CLASSES-1 → RESULT.
  - Early tlast (beat < NUM_CLASSES-1) → RESULT with frame_err. The argmax is taken over the beats received.
  - No tlast on beat NUM_CLASSES-1 → DRAIN with the error flag set.
- DRAIN:
  - s00_axis_tready=1.
  - Beats are discarded until the tlast beat is accepted, then → RESULT.
- RESULT (exactly one cycle):
  - class_valid=1, class_out=max index, correct=(max index==label), frame_err=error flag.
  - total_cnt+1; correct_cnt+1 if correct.
  - Next state WAIT_LABEL; label_ready asserts the following cycle.
- Timing:
  - Latency from the final handshake to class_valid is 1 cycle.
  - Throughput is NUM_CLASSES + 2 cycles per frame minimum (label, beats, result).
- Counters:
  - Both saturate at all-ones and never wrap.
  - clear zeroes both. If clear coincides with a RESULT increment, clear wins and the counters read 0.
  - clear does not affect the FSM or the result outputs.
- Stalls: tvalid low in RECV/DRAIN holds the state with no side effects. Beats or labels offered outside their accepting state are not consumed (ready is low).
- Reset mid-frame: partial frame is dropped, counters return to 0, no class_valid.
- tdata, tlast and label_data are sampled only on their handshake cycles.

Test Plan:
- Label 7, then scores 0..9 with 9 → value 100 at index 7, tlast on beat 9 → class_out=7, correct=1, frame_err=0, total_cnt=1, correct_cnt=1.
- Label 2, then scores with equal maximum 50 at indices 3 and 6 (others −20) → class_out=3, correct=0, correct_cnt unchanged, total_cnt increments.
- All-negative scores −1000..−991 (index 9 = −991), label 9 → class_out=9, correct=1; checks the signed compare.
- tlast on beat 4 (of 10) with maximum at index 2, label 2 → frame_err=1, class_out=2, correct=1. Then 12 beats with tlast on beat 11 → frame_err=1 after beat 11, argmax from beats 0..9 only.
- Random tvalid gaps plus a label offered during RECV → label not accepted until WAIT_LABEL. Results match the gap-free run.
- CNT_WIDTH=4: 20 correct frames → both counters stick at 15. Then assert clear in the same cycle as a RESULT → both counters read 0. Then assert reset during beat 5 → outputs 0, label_ready=1, no class_valid.
